multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle MIPS control unit: a Moore state machine that sequences each instruction over 3–5 cycles instead of decoding it in one cycle. It reuses the single-cycle opcode map and `ALUOp` encoding, and adds:
- memory-ready stalls
- instruction-done and illegal-opcode reporting
- parametrised opcode and `ALUOp` widths

It sits between the instruction register (`Op`) and the shared-memory/ALU datapath.

## Interface
Parameters:
- `OP_W`, 6, opcode width
- `ALUOP_W`, 3, `ALUOp` width (≥3)

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `Op`  in  `OP_W`  opcode from instruction register; sampled in DECODE only
- `mem_ready`  in  1  memory completed access this cycle
- `PCWrite`  out  1  unconditional PC load
- `Branch`  out  1  conditional PC load (PC loads if ALU zero)
- `jump`  out  1  select jump target
- `IorD`  out  1  memory address: 0 = PC, 1 = ALUOut
- `MemToRead`  out  1  memory read strobe
- `MemToWrite`  out  1  memory write strobe
- `IRWrite`  out  1  instruction register load
- `RegDst`  out  1  write register: 0 = rt, 1 = rd
- `MemToReg`  out  1  write data: 0 = ALUOut, 1 = MDR
- `RegWrite`  out  1  register-file write
- `ALUSrcA`  out  1  ALU A: 0 = PC, 1 = rs
- `ALUSrcB`  out  2  ALU B: 00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- `ALUOp`  out  `ALUOP_W`  ALU operation: 000 = add, 001 = R-type (funct), 010 = sub
- `instr_done`  out  1  one-cycle pulse in an instruction's final state
- `illegal_op`  out  1  one-cycle pulse on an unknown opcode
- `state`  out  4  current state code, for debug

## Operation
States (4-bit codes):
- FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
- EXEC = 6, ALUWB = 7, BRANCH = 8, JUMP = 9, ADDIEX = 10, ADDIWB = 11

Transitions:
- FETCH → DECODE when `mem_ready`; otherwise hold in FETCH.
- DECODE → next state by `Op`:
  - 000000 → EXEC
  - 100011 (lw) → MEMADR
  - 101011 (sw) → MEMADR
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000 (addi) → ADDIEX
  - anything else → FETCH, with `illegal_op` = 1 in DECODE
- MEMADR → MEMRD for lw, MEMWR for sw. MEMADR re-reads `Op`; the instruction register is stable because `IRWrite` = 0.
- MEMRD → MEMWB when `mem_ready`; else hold.
- MEMWR → FETCH when `mem_ready`; else hold.
- EXEC → ALUWB; ADDIEX → ADDIWB.
- MEMWB, ALUWB, ADDIWB, BRANCH, JUMP → FETCH.
- Unused codes 12–15 → FETCH on the next edge; all outputs 0 while in them.

Outputs (Moore; every output not listed is 0):
- FETCH: `MemToRead`, `IRWrite`, `ALUSrcB` = 01, `ALUOp` = 000. `PCWrite` = `mem_ready`, so PC+4 is written only on completion.
- DECODE: `ALUSrcB` = 11, `ALUOp` = 000 (branch-target precompute).
- MEMADR: `ALUSrcA`, `ALUSrcB` = 10, `ALUOp` = 000.
- MEMRD: `MemToRead`, `IorD`.
- MEMWB: `RegWrite`, `MemToReg`; `RegDst` = 0.
- MEMWR: `MemToWrite`, `IorD`.
- EXEC: `ALUSrcA`, `ALUSrcB` = 00, `ALUOp` = 001.
- ALUWB: `RegWrite`, `RegDst`.
- BRANCH: `ALUSrcA`, `ALUSrcB` = 00, `ALUOp` = 010, `Branch`.
- JUMP: `jump`, `PCWrite`.
- ADDIEX: `ALUSrcA`, `ALUSrcB` = 10, `ALUOp` = 000.
- ADDIWB: `RegWrite`; `RegDst` = 0.
- `instr_done` = 1 in MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, and in MEMWR when `mem_ready` = 1.
- `ALUOp` values are zero-extended to `ALUOP_W`.

## Timing
- Reset: `rst_n` low asynchronously forces the state to FETCH. While `rst_n` = 0, all outputs are forced to 0, including the FETCH strobes; `state` reads 0.
- Reset release: FETCH outputs appear in the cycle after the first edge with `rst_n` = 1.
- Reset mid-instruction abandons the instruction; no partial write strobe is produced after reset asserts.
- Latency from FETCH entry to return to FETCH, with `mem_ready` tied to 1:
  - R-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - addi: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles
  - illegal opcode: 2 cycles
- Each cycle with `mem_ready` = 0 in FETCH, MEMRD or MEMWR adds one cycle. Read/write strobes stay asserted and stable during the stall.
- `mem_ready` is ignored in all other states.

## Structure
- Shared `ud_pkg.vh` holds:
  - state codes
  - opcode constants: `OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_J`, `OP_ADDI`
  - `ALUOp` codes: `ALU_ADD`, `ALU_FUNCT`, `ALU_SUB`
  - `ALUSrcB` select codes
- One sub-module, `ud_out_decode`: a combinational state → control-word map instantiated by `multicycle_control`. The state register and next-state logic remain in the top module.

## Test plan
- Reset: hold `rst_n` = 0 in mid-MEMRD → all outputs 0, `state` = 0. After release, FETCH gives `MemToRead` = 1, `IRWrite` = 1, `ALUSrcB` = 01.
- R-type, `Op` = 000000, `mem_ready` = 1 → state sequence 0, 1, 6, 7, 0. In EXEC `ALUOp` = 001; in ALUWB `RegWrite` = 1, `RegDst` = 1; `instr_done` pulses once.
- lw, `Op` = 100011, `mem_ready` = 0 for 3 cycles in MEMRD → `MemToRead` = 1 and `IorD` = 1 held for 4 cycles, then MEMWB with `MemToReg` = 1. Total 8 cycles.
- sw, `Op` = 101011, then beq, `Op` = 000100 → sw gives `MemToWrite` = 1 in MEMWR and no `RegWrite` at any point; beq gives `Branch` = 1 with `ALUOp` = 010. Latencies 4 and 3 cycles.
- j, `Op` = 000010 → JUMP with `jump` = 1 and `PCWrite` = 1, back to FETCH after 3 cycles. Then `Op` = 111111 → `illegal_op` pulses in DECODE, no write strobes, FETCH on the next edge.
- FETCH stall: `mem_ready` = 0 for 5 cycles → `PCWrite` = 0 and state held at 0. `PCWrite` = 1 only in the cycle `mem_ready` rises.

Source files
------------

// File: rtl/ud_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes, opcodes,
// ALU operation codes, ALU B-source selects and the per-state control word.
package ud_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_FUNCT = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef struct packed {
    logic       pcWrite;
    logic       branch;
    logic       jump;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic       instrDone;
  } ctrl_t;

endpackage

// File: rtl/ud_out_decode.sv
// State -> control-word map for the multicycle control unit; purely combinational.
// memReady only qualifies the FETCH PC update and the MEMWR completion pulse.
module ud_out_decode
  import ud_pkg::*;
(
  input  state_t curState,
  input  logic   memReady,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (curState)
      S_FETCH: begin
        ctrl.memRead = 1'b1;
        ctrl.irWrite = 1'b1;
        ctrl.aluSrcB = SRCB_FOUR;
        ctrl.aluOp   = ALU_ADD;
        ctrl.pcWrite = memReady;
      end
      S_DECODE: begin
        ctrl.aluSrcB = SRCB_IMMSH;
        ctrl.aluOp   = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.memRead = 1'b1;
        ctrl.iorD    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regWrite  = 1'b1;
        ctrl.memToReg  = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      S_MEMWR: begin
        ctrl.memWrite  = 1'b1;
        ctrl.iorD      = 1'b1;
        ctrl.instrDone = memReady;
      end
      S_EXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_RT;
        ctrl.aluOp   = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regWrite  = 1'b1;
        ctrl.regDst    = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      S_BRANCH: begin
        ctrl.aluSrcA   = 1'b1;
        ctrl.aluSrcB   = SRCB_RT;
        ctrl.aluOp     = ALU_SUB;
        ctrl.branch    = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      S_JUMP: begin
        ctrl.jump      = 1'b1;
        ctrl.pcWrite   = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.regWrite  = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: 3-5 cycles per instruction, outputs decoded from state.
// Stalls in FETCH/MEMRD/MEMWR while mem_ready is low; strobes held steady meanwhile.
module multicycle_control
  import ud_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    Op,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               Branch,
  output logic               jump,
  output logic               IorD,
  output logic               MemToRead,
  output logic               MemToWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemToReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [3:0]         state
);

  state_t curState;
  state_t decodeTarget;
  logic   opKnown;
  logic   runFlag;
  ctrl_t  ctrl;
  ctrl_t  ctrlGated;

  always_comb begin
    opKnown = 1'b1;
    if (Op == OP_W'(OP_RTYPE))                          decodeTarget = S_EXEC;
    else if (Op == OP_W'(OP_LW) || Op == OP_W'(OP_SW)) decodeTarget = S_MEMADR;
    else if (Op == OP_W'(OP_BEQ))                       decodeTarget = S_BRANCH;
    else if (Op == OP_W'(OP_J))                         decodeTarget = S_JUMP;
    else if (Op == OP_W'(OP_ADDI))                      decodeTarget = S_ADDIEX;
    else begin
      decodeTarget = S_FETCH;
      opKnown      = 1'b0;
    end
  end

  // runFlag keeps every output quiet through reset and the first clock edge after it,
  // so FETCH strobes only appear once the FSM is actually sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curState <= S_FETCH;
      runFlag  <= 1'b0;
    end else if (!runFlag) begin
      runFlag <= 1'b1;
    end else begin
      case (curState)
        S_FETCH:  if (mem_ready) curState <= S_DECODE;
        S_DECODE: curState <= decodeTarget;
        S_MEMADR: curState <= (Op == OP_W'(OP_SW)) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) curState <= S_MEMWB;
        S_MEMWR:  if (mem_ready) curState <= S_FETCH;
        S_EXEC:   curState <= S_ALUWB;
        S_ADDIEX: curState <= S_ADDIWB;
        default:  curState <= S_FETCH;
      endcase
    end
  end

  ud_out_decode uOutDecode (
    .curState (curState),
    .memReady (mem_ready),
    .ctrl     (ctrl)
  );

  assign ctrlGated  = runFlag ? ctrl : '0;
  assign PCWrite    = ctrlGated.pcWrite;
  assign Branch     = ctrlGated.branch;
  assign jump       = ctrlGated.jump;
  assign IorD       = ctrlGated.iorD;
  assign MemToRead  = ctrlGated.memRead;
  assign MemToWrite = ctrlGated.memWrite;
  assign IRWrite    = ctrlGated.irWrite;
  assign RegDst     = ctrlGated.regDst;
  assign MemToReg   = ctrlGated.memToReg;
  assign RegWrite   = ctrlGated.regWrite;
  assign ALUSrcA    = ctrlGated.aluSrcA;
  assign ALUSrcB    = ctrlGated.aluSrcB;
  assign ALUOp      = ALUOP_W'(ctrlGated.aluOp);
  assign instr_done = ctrlGated.instrDone;
  assign illegal_op = runFlag && (curState == S_DECODE) && !opKnown;
  assign state      = curState;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction strobe counts, latencies
// and key state/ALUOp points compared against a table-driven instruction model.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       memReady;
  logic       pcWrite, branch, jump, iorD, memRead, memWrite, irWrite;
  logic       regDst, memToReg, regWrite, aluSrcA, instrDone, illegalOp;
  logic [1:0] aluSrcB;
  logic [2:0] aluOp;
  logic [3:0] state;
  logic [21:0] allOut;

  int numChecks = 0;
  int numErrors = 0;

  // Instruction kinds: 0 R-type, 1 lw, 2 sw, 3 beq, 4 j, 5 addi, 6 illegal
  logic [5:0] opTab   [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
  int         baseLat [7] = '{4, 5, 4, 3, 3, 4, 2};
  int         thirdSt [7] = '{6, 2, 2, 8, 9, 10, 0};
  int         thirdAlu[7] = '{1, 0, 0, 2, 0, 0, 0};
  int         finalSt [7] = '{7, 4, 5, 8, 9, 11, 1};

  always #5 clk = ~clk;

  multicycle_control #(.OP_W(6), .ALUOP_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Op         (op),
    .mem_ready  (memReady),
    .PCWrite    (pcWrite),
    .Branch     (branch),
    .jump       (jump),
    .IorD       (iorD),
    .MemToRead  (memRead),
    .MemToWrite (memWrite),
    .IRWrite    (irWrite),
    .RegDst     (regDst),
    .MemToReg   (memToReg),
    .RegWrite   (regWrite),
    .ALUSrcA    (aluSrcA),
    .ALUSrcB    (aluSrcB),
    .ALUOp      (aluOp),
    .instr_done (instrDone),
    .illegal_op (illegalOp),
    .state      (state)
  );

  assign allOut = {pcWrite, branch, jump, iorD, memRead, memWrite, irWrite, regDst,
                   memToReg, regWrite, aluSrcA, aluSrcB, aluOp, instrDone, illegalOp, state};

  task automatic checkEq(input string tag, input int got, input int exp);
    numChecks++;
    if (got != exp) begin
      numErrors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] pickIllegal();
    logic [5:0] x;
    logic       hit;
    do begin
      x   = 6'($urandom_range(0, 63));
      hit = 1'b0;
      for (int i = 0; i < 6; i++) if (x == opTab[i]) hit = 1'b1;
    end while (hit);
    return x;
  endfunction

  // Reset from any point, then confirm quiet outputs and the first FETCH cycle.
  task automatic applyReset();
    @(posedge clk); #1;
    rst_n    = 1'b0;
    memReady = 1'b1;
    #1;
    checkEq("rstAsync", int'(allOut), 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkEq("rstHold", int'(allOut), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkEq("rstRelease", int'(allOut), 0);
    @(posedge clk); #1;
    memReady = 1'b0;
    @(negedge clk);
    checkEq("fetchRead", int'(memRead), 1);
    checkEq("fetchIrWrite", int'(irWrite), 1);
    checkEq("fetchSrcB", int'(aluSrcB), 1);
    checkEq("fetchStallPc", int'(pcWrite), 0);
    checkEq("fetchState", int'(state), 0);
  endtask

  // One instruction: fStall FETCH stall cycles, mStall MEMRD/MEMWR stall cycles.
  task automatic runInstr(input int kind, input int fStall, input int mStall);
    logic [5:0] opc;
    bit isLw, isSw, isMem;
    int len;
    int cRead = 0, cWrite = 0, cIr = 0, cPc = 0, cIorD = 0, cRegW = 0, cRegDst = 0;
    int cM2R = 0, cBr = 0, cJmp = 0, cDone = 0, cIll = 0, cSrcA = 0;
    isLw  = (kind == 1);
    isSw  = (kind == 2);
    isMem = isLw || isSw;
    opc   = (kind == 6) ? pickIllegal() : opTab[kind];
    len   = baseLat[kind] + fStall + (isMem ? mStall : 0);
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      op = opc;
      if (k < fStall)                    memReady = 1'b0;
      else if (k == fStall)              memReady = 1'b1;
      else if (isMem && k >= fStall + 3) memReady = (k == fStall + 3 + mStall);
      else                               memReady = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (k == 0) checkEq("startState", int'(state), 0);
      if (k == fStall + 1) checkEq("decodeState", int'(state), 1);
      if (k == fStall + 2 && k < len) begin
        checkEq("thirdState", int'(state), thirdSt[kind]);
        checkEq("thirdAluOp", int'(aluOp), thirdAlu[kind]);
      end
      if (k == len - 1) checkEq("finalState", int'(state), finalSt[kind]);
      cRead   += int'(memRead);   cWrite += int'(memWrite); cIr   += int'(irWrite);
      cPc     += int'(pcWrite);   cIorD  += int'(iorD);     cRegW += int'(regWrite);
      cRegDst += int'(regDst);    cM2R   += int'(memToReg); cBr   += int'(branch);
      cJmp    += int'(jump);      cDone  += int'(instrDone); cIll += int'(illegalOp);
      cSrcA   += int'(aluSrcA);
    end
    checkEq("cntMemRead", cRead, fStall + 1 + (isLw ? mStall + 1 : 0));
    checkEq("cntMemWrite", cWrite, isSw ? mStall + 1 : 0);
    checkEq("cntIorD", cIorD, isMem ? mStall + 1 : 0);
    checkEq("cntIrWrite", cIr, fStall + 1);
    checkEq("cntPcWrite", cPc, 1 + (kind == 4 ? 1 : 0));
    checkEq("cntRegWrite", cRegW, (kind == 0 || isLw || kind == 5) ? 1 : 0);
    checkEq("cntRegDst", cRegDst, (kind == 0) ? 1 : 0);
    checkEq("cntMemToReg", cM2R, isLw ? 1 : 0);
    checkEq("cntBranch", cBr, (kind == 3) ? 1 : 0);
    checkEq("cntJump", cJmp, (kind == 4) ? 1 : 0);
    checkEq("cntAluSrcA", cSrcA, (kind == 4 || kind == 6) ? 0 : 1);
    checkEq("cntInstrDone", cDone, (kind == 6) ? 0 : 1);
    checkEq("cntIllegal", cIll, (kind == 6) ? 1 : 0);
  endtask

  // lw stalled in MEMRD, then reset lands mid-instruction.
  task automatic midLwReset();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      op       = 6'b100011;
      memReady = (k >= 3) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    checkEq("preRstState", int'(state), 3);
    checkEq("preRstRead", int'(memRead), 1);
    applyReset();
  endtask

  initial begin
    rst_n    = 1'b0;
    op       = 6'b000000;
    memReady = 1'b0;
    applyReset();
    runInstr(0, 5, 0);
    runInstr(1, 0, 3);
    runInstr(2, 0, 0);
    runInstr(3, 0, 0);
    runInstr(4, 0, 0);
    runInstr(6, 0, 0);
    runInstr(5, 1, 0);
    midLwReset();
    for (int n = 0; n < 60; n++) begin
      runInstr($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    midLwReset();
    runInstr(2, 2, 2);
    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
